modmul_arbiter: RTL
===================

# modmul_arbiter

Round-robin arbiter and sequencer that shares one `ModMulFast` modular multiplier among `NUM_REQ` requesters in the key-generation datapath. Each requester presents a signed operand pair. The arbiter accepts one request at a time, latches the operands and the shared modulus, and pulses `start` into the multiplier. It waits for `done` and returns the product to the owning requester with a one-cycle valid pulse. It drives the multiplier's ports directly, and the multiplier is instantiated alongside it.

## Interface
- `DATA_WIDTH`, default 32: operand, modulus and result width, signed two's complement.
- `NUM_REQ`, default 4: number of requesters, at least 2.
- `IDX_W`, default `$clog2(NUM_REQ)`: width of the grant index.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, NUM_REQ: request per requester.
- `req_a`, input, NUM_REQ*DATA_WIDTH: packed operand a; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_b`, input, NUM_REQ*DATA_WIDTH: packed operand b, same packing as `req_a`.
- `Q`, input, DATA_WIDTH: shared modulus, sampled at accept.
- `req_ready`, output, NUM_REQ: one-hot accept pulse, one cycle long.
- `rsp_valid`, output, NUM_REQ: one-hot result pulse, one cycle long.
- `rsp_data`, output, DATA_WIDTH: result, broadcast to all requesters; meaningful only while `rsp_valid` is nonzero.
- `busy`, output, 1: high in every state except IDLE.
- `err_spurious`, output, 1: sticky flag; set when `mm_done` arrives outside WAIT.
- `mm_start`, output, 1: start pulse to the multiplier.
- `mm_a`, output, DATA_WIDTH: operand a to the multiplier.
- `mm_b`, output, DATA_WIDTH: operand b to the multiplier.
- `mm_Q`, output, DATA_WIDTH: modulus to the multiplier.
- `mm_ready`, input, 1: multiplier idle.
- `mm_done`, input, 1: multiplier result valid.
- `mm_result`, input, DATA_WIDTH: the multiplier's `ab_mod_Q`.

## Operation
- The state machine has four states: IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - Acts when some `req_valid` bit is set and `mm_ready` is 1.
  - Selects grant g as the first set bit searching upward from `last_grant+1`, wrapping at `NUM_REQ`.
  - Latches `req_a[g]`, `req_b[g]`, `Q` and g.
  - Pulses `req_ready[g]` and sets `last_grant` to g.
  - Moves to ISSUE.
  - If `mm_ready` is 0, it holds in IDLE and does not accept.
- **ISSUE**: `mm_start` is 1 for exactly this one cycle; next state is WAIT.
- **WAIT**
  - Holds until `mm_done` is 1.
  - On that cycle it registers `mm_result` into `rsp_data` and moves to RESP.
- **RESP**: `rsp_valid[g]` is 1 for one cycle; next state is IDLE.
- `mm_a`, `mm_b` and `mm_Q` come from the latched registers and stay stable from ISSUE through WAIT.
- Operands and result pass through unmodified. The arbiter performs no arithmetic and no range check.
- A requester deasserts `req_valid` in the cycle after its `req_ready` pulse. A `req_valid` that stays high is treated as a new request.
- A requester that drops `req_valid` before it is accepted is dropped silently.
- Fairness: a continuously requesting requester is granted within `NUM_REQ` grants.
- `mm_done` in IDLE, ISSUE or RESP is ignored for data and sets `err_spurious`.

## Timing
- Reset values:
  - state IDLE and `last_grant` = `NUM_REQ-1`, so requester 0 wins first.
  - `req_ready`, `rsp_valid`, `mm_start`, `busy` and `err_spurious` all 0.
  - `mm_a`, `mm_b`, `mm_Q` and `rsp_data` all 0.
- Reset asserted mid-operation (ISSUE, WAIT or RESP) abandons the operation: no `rsp_valid` is produced, and a later `mm_done` is ignored without setting `err_spurious`.
- With accept at cycle t and multiplier latency L (cycles from `mm_start` to `mm_done`):
  - `mm_start` is high at t+1.
  - `mm_done` arrives at t+1+L.
  - `rsp_valid` and `rsp_data` are presented at t+2+L.
  - The next accept is possible at t+3+L.
- Back-to-back throughput is one operation per L+3 cycles.
- All outputs are registered. There is no combinational path from `req_valid` to `req_ready`.

## Structure
- A shared package `tfhe_pkg` holds the `DATA_WIDTH` default and the state encoding constants (IDLE=0, ISSUE=1, WAIT=2, RESP=3).
- Sub-module `rr_picker` is combinational. It takes the request vector and `last_grant` and returns a grant index plus an any-grant flag. It is reused by later arbiters.
- `ModMulFast` is instantiated beside the arbiter, not inside it.

## Test plan
All scenarios use a multiplier model with L=5.
- Single request, requester 0, a = b = 0x00200000, Q = 0x7FFFF000:
  - `req_ready[0]` at t, `mm_start` at t+1.
  - `rsp_valid[0]` at t+7 with `rsp_data` = 0x00800000.
- All four requesters valid simultaneously, each with distinct a and b=1, Q=0x7FFFF000:
  - grant order is 0, 1, 2, 3, each `rsp_data` equals its a.
  - accepts are spaced 8 cycles apart.
- Requester 2 holds `req_valid` continuously while requester 1 requests once:
  - grants alternate 1, 2, 2, …
  - requester 1 waits no more than one operation.
- `mm_ready` = 0 with requests pending: no `req_ready` and `busy` = 0. When `mm_ready` rises, the accept follows on the next edge.
- `rst` pulsed during WAIT, then `mm_done` arrives: all outputs read 0, `err_spurious` stays 0, no `rsp_valid`, and requester 0 has priority again.
- `mm_done` pulsed while in IDLE: `err_spurious` = 1 and stays 1 until reset; no `rsp_valid`.

Source files
------------

// File: rtl/tfhe_pkg.sv
// Shared definitions for the key-generation datapath arbiters.
package tfhe_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/modmul_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request above last_grant, wrapping.
module rr_picker
    import tfhe_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant,
    output logic               any_grant
);

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = last_grant;
        any_grant = 1'b0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (req[idx]) begin
                grant     = IDX_W'(idx);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/modmul_arbiter.sv
// Round-robin sequencer sharing one ModMulFast multiplier among NUM_REQ requesters.
module modmul_arbiter
    import tfhe_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REQ    = 4,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
    input  logic signed [DATA_WIDTH-1:0]   Q,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic signed [DATA_WIDTH-1:0]   rsp_data,
    output logic                           busy,
    output logic                           err_spurious,
    output logic                           mm_start,
    output logic signed [DATA_WIDTH-1:0]   mm_a,
    output logic signed [DATA_WIDTH-1:0]   mm_b,
    output logic signed [DATA_WIDTH-1:0]   mm_Q,
    input  logic                           mm_ready,
    input  logic                           mm_done,
    input  logic signed [DATA_WIDTH-1:0]   mm_result
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             accept;
    logic             done_ok;
    logic             orphan;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick_idx),
        .any_grant  (pick_any)
    );

    // A done belonging to an operation abandoned by reset is never ours.
    assign done_ok = (state == ST_WAIT) && mm_done && !orphan;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (|req_ready) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (done_ok) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The grant is registered on the edge that lands in IDLE, so req_ready is
    // visible during the IDLE cycle and RESP overlaps the next pick.
    assign accept = (state_nxt == ST_IDLE) && pick_any && mm_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            last_grant   <= IDX_W'(NUM_REQ - 1);
            req_ready    <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            busy         <= 1'b0;
            err_spurious <= 1'b0;
            mm_start     <= 1'b0;
            mm_a         <= '0;
            mm_b         <= '0;
            mm_Q         <= '0;
            orphan       <= (state == ST_ISSUE) || (state == ST_WAIT) || (orphan && !mm_done);
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != ST_IDLE);
            mm_start  <= (state_nxt == ST_ISSUE);
            req_ready <= '0;
            rsp_valid <= done_ok ? onehot(last_grant) : '0;

            if (accept) begin
                req_ready  <= onehot(pick_idx);
                last_grant <= pick_idx;
                mm_a       <= req_a[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                mm_b       <= req_b[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                mm_Q       <= Q;
            end

            if (done_ok) begin
                rsp_data <= mm_result;
            end

            // An idle multiplier has nothing left from an abandoned operation.
            if (mm_done) begin
                if (orphan) begin
                    orphan <= 1'b0;
                end else if (state != ST_WAIT) begin
                    err_spurious <= 1'b1;
                end
            end else if (mm_ready) begin
                orphan <= 1'b0;
            end
        end
    end

endmodule
